adsr: RTL and testbench

- Per-voice ADSR envelope generator fused with a signed sample amplifier; next generation of the two-stage attack/release voice gate.
- Adds a decay stage and a sustain level, retrigger from current level, parametrised envelope resolution and a registered output.
- Sits between an oscillator/mixer voice and the voice summer.
- Runs once per sample tick on the sample clock.

---
 rtl/audio_pkg.sv | 15 +
 rtl/adsr_amp.sv | 23 ++
 rtl/adsr.sv | 99 +++++++++
 tb/tb_adsr.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared audio widths and ADSR state encodings
package audio_pkg;

    localparam int AUDIO_BITDEPTH = 14;
    localparam int AUDIO_ENVBITS  = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } adsr_state_t;

endpackage

// File: rtl/adsr_amp.sv
// adsr_amp: registered signed sample times unsigned gain, truncated toward -inf
module adsr_amp
    import audio_pkg::*;
#(
    parameter int BITDEPTH = AUDIO_BITDEPTH,
    parameter int ENVBITS  = AUDIO_ENVBITS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [BITDEPTH-1:0] smp,
    input  logic        [ENVBITS-1:0]  vol,
    output logic signed [BITDEPTH-1:0] out
);

    logic signed [BITDEPTH+ENVBITS-1:0] prod;

    assign prod = smp * $signed({1'b0, vol});

    // gain below unity means the shifted product always fits the sample width
    always_ff @(posedge clk)
        out <= rst ? '0 : BITDEPTH'(prod >>> ENVBITS);

endmodule

// File: rtl/adsr.sv
// adsr: ADSR envelope generator driving a registered signed amplifier
module adsr
    import audio_pkg::*;
#(
    parameter int BITDEPTH = AUDIO_BITDEPTH,
    parameter int ENVBITS  = AUDIO_ENVBITS,
    parameter int FRACBITS = 8,
    parameter int RATEBITS = 8
) (
    input  logic                       sample_clock,
    input  logic                       reset,
    input  logic signed [BITDEPTH-1:0] in,
    input  logic                       gate,
    input  logic        [RATEBITS-1:0] attack,
    input  logic        [RATEBITS-1:0] decay,
    input  logic        [ENVBITS-1:0]  sustain,
    input  logic        [RATEBITS-1:0] release_rate,
    output logic signed [BITDEPTH-1:0] out,
    output logic        [ENVBITS-1:0]  volume,
    output logic        [2:0]          state,
    output logic                       active
);

    localparam int LW = ENVBITS + FRACBITS;
    localparam logic [LW:0] LMAX = {1'b0, {LW{1'b1}}};

    adsr_state_t         st_q, st_n;
    logic [LW-1:0]       lvl_q, lvl_n, dn;
    logic [LW:0]         lvl_x, sus_x, step, up, dn_lim;
    logic [RATEBITS-1:0] rate;
    logic                gate_d, rise, fall;

    assign rise   = gate & ~gate_d;
    assign fall   = ~gate & gate_d;
    assign rate   = st_q == ATTACK ? attack : st_q == DECAY ? decay : release_rate;
    assign step   = (LW+1)'(rate) + (LW+1)'(1);
    assign lvl_x  = {1'b0, lvl_q};
    assign sus_x  = {1'b0, sustain, {FRACBITS{1'b0}}};
    assign up     = lvl_x + step;
    assign dn_lim = sus_x + step;
    assign dn     = lvl_q - step[LW-1:0];

    // edges only move the state; the level advances on non-edge cycles, saturating at both ends
    always_comb begin
        st_n  = st_q;
        lvl_n = lvl_q;
        if (rise)
            st_n = ATTACK;
        else if (fall)
            st_n = st_q inside {ATTACK, DECAY, SUSTAIN} ? RELEASE : st_q;
        else
            case (st_q)
                IDLE:    lvl_n = '0;
                ATTACK:  begin
                    st_n  = up > LMAX ? DECAY : ATTACK;
                    lvl_n = up > LMAX ? LMAX[LW-1:0] : up[LW-1:0];
                end
                DECAY:   begin
                    st_n  = lvl_x <= dn_lim ? SUSTAIN : DECAY;
                    lvl_n = lvl_x <= dn_lim ? sus_x[LW-1:0] : dn;
                end
                SUSTAIN: lvl_n = sus_x[LW-1:0];
                RELEASE: begin
                    st_n  = lvl_x <= step ? IDLE : RELEASE;
                    lvl_n = lvl_x <= step ? '0 : dn;
                end
                default: begin
                    st_n  = IDLE;
                    lvl_n = '0;
                end
            endcase
    end

    // state, level and gate history registers
    always_ff @(posedge sample_clock) begin
        if (reset) begin
            st_q   <= IDLE;
            lvl_q  <= '0;
            gate_d <= 1'b0;
        end else begin
            st_q   <= st_n;
            lvl_q  <= lvl_n;
            gate_d <= gate;
        end
    end

    assign volume = lvl_q[LW-1 -: ENVBITS];
    assign state  = st_q;
    assign active = st_q != IDLE;

    adsr_amp #(.BITDEPTH(BITDEPTH), .ENVBITS(ENVBITS)) u_amp (
        .clk (sample_clock),
        .rst (reset),
        .smp (in),
        .vol (volume),
        .out (out)
    );

endmodule

// File: tb/tb_adsr.sv
// tb_adsr: directed checks of envelope stages, retrigger, amplifier and reset
module tb_adsr;

    logic               sample_clock = 0;
    logic               reset = 1;
    logic signed [13:0] in = 0;
    logic               gate = 0;
    logic        [7:0]  attack = 255, decay = 255, sustain = 8'h80, release_rate = 0;
    logic signed [13:0] out;
    logic        [7:0]  volume;
    logic        [2:0]  state;
    logic               active;
    int                 tests = 0, fails = 0;

    adsr dut (
        .sample_clock (sample_clock),
        .reset        (reset),
        .in           (in),
        .gate         (gate),
        .attack       (attack),
        .decay        (decay),
        .sustain      (sustain),
        .release_rate (release_rate),
        .out          (out),
        .volume       (volume),
        .state        (state),
        .active       (active)
    );

    always #5 sample_clock = ~sample_clock;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge sample_clock);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1;
        tick(2);
        tests += 4;
        if (state !== 3'd0) begin fails++; $display("FAIL reset_state got %0d want 0", state); end
        if (volume !== 8'd0) begin fails++; $display("FAIL reset_volume got %0d want 0", volume); end
        if (out !== 14'sd0) begin fails++; $display("FAIL reset_out got %0d want 0", out); end
        if (active !== 1'b0) begin fails++; $display("FAIL reset_active got %0b want 0", active); end
        reset = 0;
        tick();
    endtask

    task automatic test_attack;
        gate = 1;
        tick();
        tests += 3;
        if (state !== 3'd1) begin fails++; $display("FAIL attack_enter got %0d want 1", state); end
        if (volume !== 8'd0) begin fails++; $display("FAIL attack_edge_level got %0d want 0", volume); end
        if (active !== 1'b1) begin fails++; $display("FAIL attack_active got %0b want 1", active); end
        tick(254);
        tests += 2;
        if (volume !== 8'd254) begin fails++; $display("FAIL attack_254 got %0d want 254", volume); end
        if (state !== 3'd1) begin fails++; $display("FAIL attack_254_state got %0d want 1", state); end
        tick();
        tests += 2;
        if (volume !== 8'd255) begin fails++; $display("FAIL attack_255 got %0d want 255", volume); end
        if (state !== 3'd1) begin fails++; $display("FAIL attack_255_state got %0d want 1", state); end
        tick();
        tests += 2;
        if (state !== 3'd2) begin fails++; $display("FAIL attack_top_state got %0d want 2", state); end
        if (volume !== 8'd255) begin fails++; $display("FAIL attack_top_volume got %0d want 255", volume); end
    endtask

    task automatic test_decay;
        tick(127);
        tests += 2;
        if (state !== 3'd2) begin fails++; $display("FAIL decay_127_state got %0d want 2", state); end
        if (volume !== 8'h80) begin fails++; $display("FAIL decay_127_volume got %0h want 80", volume); end
        tick();
        tests += 2;
        if (state !== 3'd3) begin fails++; $display("FAIL decay_sustain_state got %0d want 3", state); end
        if (volume !== 8'h80) begin fails++; $display("FAIL decay_sustain_volume got %0h want 80", volume); end
        tick(3);
        tests += 1;
        if (volume !== 8'h80) begin fails++; $display("FAIL sustain_hold got %0h want 80", volume); end
    endtask

    task automatic test_amp;
        in = -14'sd8192;
        tick();
        tests += 1;
        if (out !== -14'sd4096) begin fails++; $display("FAIL amp_neg_full got %0d want -4096", out); end
        in = 14'sd8191;
        tick();
        tests += 1;
        if (out !== 14'sd4095) begin fails++; $display("FAIL amp_pos_full got %0d want 4095", out); end
        sustain = 8'h40;
        tick();
        tests += 2;
        if (volume !== 8'h40) begin fails++; $display("FAIL sustain_live got %0h want 40", volume); end
        if (out !== 14'sd4095) begin fails++; $display("FAIL amp_latency got %0d want 4095", out); end
        tick();
        tests += 1;
        if (out !== 14'sd2047) begin fails++; $display("FAIL amp_quarter got %0d want 2047", out); end
        in = -14'sd1;
        tick();
        tests += 1;
        if (out !== -14'sd1) begin fails++; $display("FAIL amp_floor got %0d want -1", out); end
        sustain = 8'h00;
        tick(2);
        tests += 2;
        if (volume !== 8'h00) begin fails++; $display("FAIL sustain_zero got %0h want 0", volume); end
        if (out !== 14'sd0) begin fails++; $display("FAIL amp_zero_gain got %0d want 0", out); end
        sustain = 8'h80;
        in = 14'sd1000;
    endtask

    task automatic test_release;
        reset = 1;
        gate = 0;
        tick();
        reset = 0;
        tick();
        gate = 1;
        tick();
        tick(64);
        tests += 1;
        if (volume !== 8'h40) begin fails++; $display("FAIL release_start_level got %0h want 40", volume); end
        gate = 0;
        tick();
        tests += 2;
        if (state !== 3'd4) begin fails++; $display("FAIL release_enter got %0d want 4", state); end
        if (volume !== 8'h40) begin fails++; $display("FAIL release_edge_level got %0h want 40", volume); end
        tick(16383);
        tests += 2;
        if (state !== 3'd4) begin fails++; $display("FAIL release_16383_state got %0d want 4", state); end
        if (volume !== 8'h00) begin fails++; $display("FAIL release_16383_volume got %0h want 0", volume); end
        tick();
        tests += 3;
        if (state !== 3'd0) begin fails++; $display("FAIL release_idle got %0d want 0", state); end
        if (active !== 1'b0) begin fails++; $display("FAIL release_active got %0b want 0", active); end
        if (out !== 14'sd0) begin fails++; $display("FAIL release_out got %0d want 0", out); end
    endtask

    task automatic test_retrigger;
        gate = 1;
        tick();
        tick(48);
        gate = 0;
        tick();
        tests += 2;
        if (state !== 3'd4) begin fails++; $display("FAIL retrig_release got %0d want 4", state); end
        if (volume !== 8'h30) begin fails++; $display("FAIL retrig_release_level got %0h want 30", volume); end
        gate = 1;
        tick();
        tests += 2;
        if (state !== 3'd1) begin fails++; $display("FAIL retrig_attack got %0d want 1", state); end
        if (volume !== 8'h30) begin fails++; $display("FAIL retrig_hold_level got %0h want 30", volume); end
        tick();
        tests += 1;
        if (volume !== 8'h31) begin fails++; $display("FAIL retrig_rise got %0h want 31", volume); end
    endtask

    task automatic test_reset_mid_note;
        int n = 0;
        while (state !== 3'd2 && n < 400) begin
            tick();
            n++;
        end
        tests += 1;
        if (state !== 3'd2) begin fails++; $display("FAIL reach_decay timeout state %0d want 2", state); end
        tick(5);
        reset = 1;
        tick();
        reset = 0;
        tests += 4;
        if (state !== 3'd0) begin fails++; $display("FAIL midreset_state got %0d want 0", state); end
        if (volume !== 8'd0) begin fails++; $display("FAIL midreset_volume got %0d want 0", volume); end
        if (out !== 14'sd0) begin fails++; $display("FAIL midreset_out got %0d want 0", out); end
        if (active !== 1'b0) begin fails++; $display("FAIL midreset_active got %0b want 0", active); end
        tick();
        tests += 2;
        if (state !== 3'd1) begin fails++; $display("FAIL midreset_retrigger got %0d want 1", state); end
        if (volume !== 8'd0) begin fails++; $display("FAIL midreset_level got %0d want 0", volume); end
    endtask

    initial begin
        test_reset();
        test_attack();
        test_decay();
        test_amp();
        test_release();
        test_retrigger();
        test_reset_mid_note();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
